// File: rtl/aes_round_sequencer.sv
// Iterative AES-128 round sequencer: one shared round datapath reused for NR rounds per block.
// Optional macro AES_KEY_STALL_EN adds rk_valid so the key schedule can stall the sequence.
module aes_round_sequencer #(
  parameter int NR = 10
) (
  input  logic           clk,
  input  logic           reset,
  input  logic           start,
  output logic           ready,
  input  logic [0:127]   plaintext,
  output logic [3:0]     round_idx,
  input  logic [0:127]   round_key,
  output logic [0:127]   sb_in,
  input  logic [0:127]   sb_out,
  output logic [0:127]   ciphertext,
  output logic           done
`ifdef AES_KEY_STALL_EN
  ,
  input  logic           rk_valid
`endif
);

  typedef enum logic [1:0] {IDLE, ROUND, FINAL, DONE} fsm_t;

  localparam logic [3:0] LAST_MID = 4'(NR - 1);
  localparam logic [3:0] LAST_IDX = 4'(NR);

  fsm_t         fsm, fsm_nxt;
  logic [3:0]   cnt, cnt_nxt;
  logic [0:127] st, st_nxt;
  logic [0:127] ct_nxt;
  logic         adv;

  function automatic logic [7:0] xtime(input logic [7:0] b);
    return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
  endfunction

  // byte (r+4c) is row r, column c; row r rotates left by r columns
  function automatic logic [0:127] shift_rows(input logic [0:127] s);
    logic [0:127] o;
    o = '0;
    for (int c = 0; c < 4; c++)
      for (int r = 0; r < 4; r++)
        o[8*(r+4*c) +: 8] = s[8*(r+4*((c+r)%4)) +: 8];
    return o;
  endfunction

  function automatic logic [0:127] mix_columns(input logic [0:127] s);
    logic [0:127] o;
    logic [7:0]   a0, a1, a2, a3;
    o = '0;
    for (int c = 0; c < 4; c++) begin
      a0 = s[32*c +: 8];
      a1 = s[32*c+8 +: 8];
      a2 = s[32*c+16 +: 8];
      a3 = s[32*c+24 +: 8];
      o[32*c +: 8]    = xtime(a0) ^ xtime(a1) ^ a1 ^ a2 ^ a3;
      o[32*c+8 +: 8]  = a0 ^ xtime(a1) ^ xtime(a2) ^ a2 ^ a3;
      o[32*c+16 +: 8] = a0 ^ a1 ^ xtime(a2) ^ xtime(a3) ^ a3;
      o[32*c+24 +: 8] = xtime(a0) ^ a0 ^ a1 ^ a2 ^ xtime(a3);
    end
    return o;
  endfunction

`ifdef AES_KEY_STALL_EN
  assign adv = rk_valid;
`else
  assign adv = 1'b1;
`endif

  always_comb begin
    fsm_nxt = fsm;
    cnt_nxt = cnt;
    st_nxt  = st;
    ct_nxt  = ciphertext;
    case (fsm)
      IDLE: begin
        if (start && adv) begin
          st_nxt  = plaintext ^ round_key;
          cnt_nxt = 4'd1;
          fsm_nxt = (NR == 1) ? FINAL : ROUND;
        end
      end
      ROUND: begin
        if (adv) begin
          st_nxt  = mix_columns(shift_rows(sb_out)) ^ round_key;
          cnt_nxt = cnt + 4'd1;
          if (cnt == LAST_MID)
            fsm_nxt = FINAL;
        end
      end
      FINAL: begin
        if (adv) begin
          ct_nxt  = shift_rows(sb_out) ^ round_key;
          fsm_nxt = DONE;
        end
      end
      DONE: begin
        cnt_nxt = '0;
        fsm_nxt = IDLE;
      end
      default: fsm_nxt = IDLE;
    endcase
  end

  // round_idx depends only on registered state so the key-schedule path has no loop
  always_comb begin
    round_idx = '0;
    case (fsm)
      ROUND:   round_idx = cnt;
      FINAL:   round_idx = LAST_IDX;
      default: round_idx = '0;
    endcase
  end

  assign ready = (fsm == IDLE);
  assign done  = (fsm == DONE);
  assign sb_in = st;

  always_ff @(posedge clk) begin
    if (reset) begin
      fsm        <= IDLE;
      cnt        <= '0;
      st         <= '0;
      ciphertext <= '0;
    end else begin
      fsm        <= fsm_nxt;
      cnt        <= cnt_nxt;
      st         <= st_nxt;
      ciphertext <= ct_nxt;
    end
  end

endmodule

// File: doc/aes_round_sequencer.md
# aes_round_sequencer

Iterative AES-128 encryption controller that sequences a single shared round datapath (SubBytes, ShiftRows, MixColumns and AddRoundKey) over NR rounds for one 128-bit block at a time. ShiftRows and the mixColumns instance are internal. The byte-substitution network and the round-key schedule are external and shared through port pairs. The block sits between the host load/start logic and the key-expansion unit, and produces one ciphertext per start.

## Interface
- NR, default 10: number of AES rounds. The final round omits MixColumns.
- clk  in  1: single clock; all state updates on the rising edge.
- reset  in  1: synchronous, active-high.
- start  in  1: request to encrypt `plaintext`; accepted only while `ready`=1.
- ready  out  1: block is idle and can accept `start`.
- plaintext  in  [0:127]: input block, sampled in the accept cycle only.
- round_idx  out  4: round-key index requested from the key schedule, 0..NR.
- round_key  in  [0:127]: round key for `round_idx`, valid combinationally in the same cycle.
- sb_in  out  [0:127]: current state register, driven to the external S-box network.
- sb_out  in  [0:127]: byte-wise S-box result for `sb_in`, combinational, same cycle.
- ciphertext  out  [0:127]: registered result; holds until the next completion.
- done  out  1: one-cycle pulse when `ciphertext` is updated.
- rk_valid  in  1: present only with AES_KEY_STALL_EN (see Configuration).

## Operation
- State byte layout matches mixColumns: byte k = bits [8k:8k+7]; byte (r+4c) is row r, column c.
- ShiftRows: out byte (r+4c) = in byte (r+4((c+r) mod 4)).
- FSM states: IDLE, ROUND, FINAL, DONE.
- **IDLE**
  - `ready`=1, `round_idx`=0.
  - On `start`: state <= plaintext ^ round_key, counter <= 1, go to ROUND. If NR=1, go to FINAL instead.
- **ROUND** (`round_idx` = counter, 1..NR-1)
  - state <= mixColumns(ShiftRows(sb_out)) ^ round_key.
  - counter increments each cycle.
  - When counter = NR-1 is consumed, go to FINAL.
- **FINAL** (`round_idx` = NR)
  - ciphertext <= ShiftRows(sb_out) ^ round_key.
  - Go to DONE.
- **DONE**
  - `done`=1 for exactly this cycle, `ready`=0.
  - Go to IDLE.
- `start` outside IDLE is ignored. It is not queued.
- `plaintext` changes after the accept cycle have no effect.
- `round_idx` is decoded from the FSM state and counter only, never from inputs, so the external key schedule path has no loop.

## Timing
- Accept at edge T (start=1 in IDLE).
- ROUND occupies cycles T+1..T+NR-1; FINAL occupies cycle T+NR.
- `done`=1 and new `ciphertext` are visible in cycle T+NR+1.
- Latency from start to done is NR+1 cycles. Throughput is one block per NR+2 cycles.
- `ready` returns to 1 in cycle T+NR+2. A start held high in that cycle is accepted.
- Reset values:
  - FSM = IDLE, counter = 0, state = 0.
  - ciphertext = 0, done = 0, ready = 1, round_idx = 0.
- Reset asserted mid-operation aborts the block with no `done` pulse. The previous `ciphertext` is cleared to 0.
- Reset has priority over `start` in the same cycle.

## Configuration
- AES_KEY_STALL_EN
  - **Defined:** adds the `rk_valid` input. In IDLE, ROUND and FINAL, a cycle with rk_valid=0 performs no state, counter or FSM update and holds `round_idx` steady. Start is accepted only when start=1 and rk_valid=1. Latency becomes NR+1 plus the number of stall cycles.
  - **Undefined:** no `rk_valid` port; `round_key` is treated as valid every cycle.

## Test plan
- FIPS-197 App. B: key 2b7e151628aed2a6abf7158809cf4f3c, plaintext 3243f6a8885a308d313198a2e0370734, bench supplies round keys by `round_idx` → `done` exactly 11 cycles after start, ciphertext 3925841d02dc09fbdc118597196a0b32.
- FIPS-197 App. C.1: key 000102…0f, plaintext 00112233445566778899aabbccddeeff → ciphertext 69c4e0d86a7b0430d8cdb78070b4c55a; `round_idx` sequence is 0,1,…,10, one value per cycle.
- Back-to-back: start held high continuously → starts accepted every 12 cycles; second result is correct; no `done` is lost or duplicated.
- Start pulsed during ROUND, and `plaintext` toggled mid-operation → ignored; the App. B result is unchanged.
- Reset asserted at round 5 → next cycle ready=1, done=0, ciphertext=0; a fresh App. C.1 run completes correctly.
- With AES_KEY_STALL_EN: rk_valid=0 for 3 cycles during round 4 → `round_idx` holds at 4, `done` arrives at start+14, ciphertext unchanged.
